// File: rtl/march_seq_gen_pkg.sv
// Shared widths, FSM state codes and op-field bit positions for the March element sequencer.
package march_seq_gen_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 4;

    // Op field: bit1 selects write (1) / read (0), bit0 inverts the background.
    localparam int OP_WR_BIT  = 1;
    localparam int OP_INV_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/march_seq_gen_addr_cnt.sv
// Loadable up/down address counter for the March sweep; flags the end address of the sweep.
module march_addr_cnt #(
    parameter int             AW       = 4,
    parameter logic [AW-1:0]  ADDR_MAX = '1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          dir,
    input  logic          en,
    output logic [AW-1:0] addr,
    output logic          last
);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_val;
        end else if (en) begin
            addr <= dir ? addr - AW'(1) : addr + AW'(1);
        end
    end

    // Descending sweeps end at 0, ascending sweeps end at ADDR_MAX.
    assign last = dir ? (addr == '0) : (addr == ADDR_MAX);

endmodule

// File: rtl/march_seq_gen.sv
// BIST March element sequencer: address sweep with 1-4 read/write ops per address.
// Optional PMBIST_CHECKERBOARD_EN adds an address-parity term to the data pattern.
module march_seq_gen
    import march_seq_gen_pkg::*;
#(
    parameter int            DW       = DATA_WIDTH,
    parameter int            AW       = ADDR_WIDTH,
    parameter logic [AW-1:0] ADDR_MAX = AW'((1 << AW) - 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_in,
    input  logic          dir_in,
    input  logic [1:0]    nops_in,
    input  logic [7:0]    ops_in,
    input  logic [DW-1:0] bg_in,
    input  logic          stall_in,
    output logic [AW-1:0] addr_out,
    output logic [DW-1:0] data_out,
    output logic          we_out,
    output logic          re_out,
    output logic [DW-1:0] exp_out,
    output logic          cmp_en_out,
    output logic          busy_out,
    output logic          done_out
);

    function automatic logic [DW-1:0] pattern(input logic [DW-1:0] bg, input logic inv);
        return bg ^ {DW{inv}};
    endfunction

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic          dir_q;
    logic [1:0]    nops_q;
    logic [7:0]    ops_q;
    logic [DW-1:0] bg_q;

    logic [AW-1:0] cnt_addr, cnt_load_val;
    logic          cnt_last, cnt_load, cnt_en;

    logic          issue, inv, wrap;
    logic [1:0]    cur_op;
    logic [DW-1:0] cur_bg;
    logic          we_d, re_d, busy_d, done_d;
    logic [DW-1:0] data_d, exp_d;
`ifdef PMBIST_CHECKERBOARD_EN
    logic          pat_lsb;
`endif

    assign cnt_load_val = dir_in ? ADDR_MAX : '0;

    march_addr_cnt #(.AW(AW), .ADDR_MAX(ADDR_MAX)) u_addr_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dir      (dir_q),
        .en       (cnt_en),
        .addr     (cnt_addr),
        .last     (cnt_last)
    );

    assign addr_out = cnt_addr;

    // The counter/idx pair always names the op currently on the outputs; an unstalled
    // RUN cycle advances it and presents the following op.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        issue    = 1'b0;
        cur_op   = 2'b00;
        cur_bg   = bg_q;
        we_d     = 1'b0;
        re_d     = 1'b0;
        busy_d   = busy_out;
        done_d   = 1'b0;
        data_d   = data_out;
        exp_d    = exp_out;
        wrap     = (idx_q == nops_q);
`ifdef PMBIST_CHECKERBOARD_EN
        pat_lsb  = cnt_addr[0];
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    state_d  = ST_RUN;
                    idx_d    = 2'd0;
                    cnt_load = 1'b1;
                    busy_d   = 1'b1;
                    issue    = 1'b1;
                    cur_op   = ops_in[1:0];
                    cur_bg   = bg_in;
`ifdef PMBIST_CHECKERBOARD_EN
                    pat_lsb  = cnt_load_val[0];
`endif
                end
            end
            ST_RUN: begin
                if (!stall_in) begin
                    if (wrap && cnt_last) begin
                        state_d = ST_DONE;
                        idx_d   = 2'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        issue = 1'b1;
                        if (wrap) begin
                            idx_d  = 2'd0;
                            cnt_en = 1'b1;
`ifdef PMBIST_CHECKERBOARD_EN
                            pat_lsb = ~cnt_addr[0];
`endif
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                        cur_op = ops_q[{idx_d, 1'b0} +: 2];
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        inv = cur_op[OP_INV_BIT];
`ifdef PMBIST_CHECKERBOARD_EN
        inv = inv ^ pat_lsb;
`endif
        if (issue) begin
            if (cur_op[OP_WR_BIT]) begin
                we_d   = 1'b1;
                data_d = pattern(cur_bg, inv);
            end else begin
                re_d   = 1'b1;
                exp_d  = pattern(cur_bg, inv);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= 2'd0;
            dir_q      <= 1'b0;
            nops_q     <= 2'd0;
            ops_q      <= 8'd0;
            bg_q       <= '0;
            data_out   <= '0;
            exp_out    <= '0;
            we_out     <= 1'b0;
            re_out     <= 1'b0;
            cmp_en_out <= 1'b0;
            busy_out   <= 1'b0;
            done_out   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            data_out   <= data_d;
            exp_out    <= exp_d;
            we_out     <= we_d;
            re_out     <= re_d;
            cmp_en_out <= re_d;
            busy_out   <= busy_d;
            done_out   <= done_d;
            if (cnt_load) begin
                dir_q  <= dir_in;
                nops_q <= nops_in;
                ops_q  <= ops_in;
                bg_q   <= bg_in;
            end
        end
    end

endmodule

// File: tb/tb_march_seq_gen.sv
// Directed bench for march_seq_gen: reset, sweeps, multi-op elements, stall, abort.
module tb_march_seq_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_in;
    logic       dir_in;
    logic [1:0] nops_in;
    logic [7:0] ops_in;
    logic [7:0] bg_in;
    logic       stall_in;
    logic [3:0] addr_out;
    logic [7:0] data_out;
    logic       we_out;
    logic       re_out;
    logic [7:0] exp_out;
    logic       cmp_en_out;
    logic       busy_out;
    logic       done_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    march_seq_gen dut (
        .clk        (clk),
        .rst        (rst),
        .start_in   (start_in),
        .dir_in     (dir_in),
        .nops_in    (nops_in),
        .ops_in     (ops_in),
        .bg_in      (bg_in),
        .stall_in   (stall_in),
        .addr_out   (addr_out),
        .data_out   (data_out),
        .we_out     (we_out),
        .re_out     (re_out),
        .exp_out    (exp_out),
        .cmp_en_out (cmp_en_out),
        .busy_out   (busy_out),
        .done_out   (done_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_strobes(input string tag, input logic we, input logic re);
        chk({tag, "_we"},  32'(we_out),     32'(we));
        chk({tag, "_re"},  32'(re_out),     32'(re));
        chk({tag, "_cmp"}, 32'(cmp_en_out), 32'(re));
    endtask

    // Runs one element and checks every op cycle against the closed-form sweep order.
    // stall_at: op number that is held off by a 3-cycle stall (-1 for none).
    task automatic run_elem(input logic dir, input logic [1:0] nops, input logic [7:0] ops,
                            input logic [7:0] bg, input int stall_at);
        int         per;
        int         n;
        int         idx;
        logic [3:0] ea;
        logic [1:0] eop;
        logic [7:0] epat;
        per = int'(nops) + 1;
        n   = 16 * per;
        @(negedge clk);
        dir_in = dir; nops_in = nops; ops_in = ops; bg_in = bg; start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0; dir_in = ~dir; nops_in = ~nops; ops_in = ~ops; bg_in = ~bg;
        for (int k = 0; k < n; k++) begin
            idx  = k % per;
            ea   = dir ? 4'(15 - k / per) : 4'(k / per);
            eop  = 2'(ops >> (2 * idx));
            epat = bg ^ {8{eop[0]}};
`ifdef PMBIST_CHECKERBOARD_EN
            epat = epat ^ {8{ea[0]}};
`endif
            chk("addr", 32'(addr_out), 32'(ea));
            chk("busy", 32'(busy_out), 32'd1);
            chk_strobes("op", eop[1], ~eop[1]);
            if (eop[1]) chk("data", 32'(data_out), 32'(epat));
            else        chk("exp",  32'(exp_out),  32'(epat));
            if (k + 1 == stall_at) begin
                stall_in = 1'b1;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    chk_strobes("stall", 1'b0, 1'b0);
                    chk("stall_addr", 32'(addr_out), 32'(ea));
                    chk("stall_busy", 32'(busy_out), 32'd1);
                    if (s == 2) stall_in = 1'b0;
                end
            end
            @(negedge clk);
        end
        chk("done", 32'(done_out), 32'd1);
        chk("done_busy", 32'(busy_out), 32'd0);
        chk_strobes("done", 1'b0, 1'b0);
        @(negedge clk);
        chk("done_pulse", 32'(done_out), 32'd0);
        chk("idle_busy", 32'(busy_out), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start_in = 1'b1; dir_in = 1'b0; nops_in = 2'd0;
        ops_in = 8'h02; bg_in = 8'h00; stall_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_addr", 32'(addr_out), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_exp",  32'(exp_out),  32'd0);
        chk_strobes("rst", 1'b0, 1'b0);
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_done", 32'(done_out), 32'd0);
        rst = 1'b0; start_in = 1'b0;
        @(negedge clk);
        chk("start_in_rst_ignored", 32'(busy_out), 32'd0);

        // Ascending w0, descending r0/w1, stalled element, checkerboard background, four ops.
        run_elem(1'b0, 2'd0, 8'h02, 8'h00, -1);
        run_elem(1'b1, 2'd1, 8'h0C, 8'h00, -1);
        run_elem(1'b0, 2'd1, 8'h0C, 8'h00, 11);
        run_elem(1'b0, 2'd0, 8'h02, 8'h55, -1);
        run_elem(1'b1, 2'd3, 8'b10_01_11_00, 8'hA3, -1);

        // Mid-run start pulse is ignored; reset at addr 7 aborts with no done.
        @(negedge clk);
        dir_in = 1'b0; nops_in = 2'd0; ops_in = 8'h02; bg_in = 8'h3C; start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("abort_addr", 32'(addr_out), 32'(k));
            chk_strobes("abort_op", 1'b1, 1'b0);
            chk("abort_data", 32'(data_out), 32'h3C);
            start_in = (k == 3);
            dir_in   = (k == 3);
            ops_in   = (k == 3) ? 8'h00 : 8'h02;
            if (k < 7) @(negedge clk);
        end
        start_in = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("abort_rst_addr", 32'(addr_out), 32'd0);
        chk("abort_rst_data", 32'(data_out), 32'd0);
        chk_strobes("abort_rst", 1'b0, 1'b0);
        chk("abort_rst_busy", 32'(busy_out), 32'd0);
        chk("abort_rst_done", 32'(done_out), 32'd0);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done_out), 32'd0);
            chk("abort_idle", 32'(busy_out), 32'd0);
        end
        run_elem(1'b0, 2'd0, 8'h02, 8'h00, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
